// File: rtl/wb_block_copy_pkg.sv
// Shared definitions for the Wishbone block copier: FSM encoding, byte-lane mask and word stride.
package wb_block_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [3:0] SEL_ALL     = 4'hF;
    localparam int         ADDR_STRIDE = 4;

endpackage

// File: rtl/wb_block_copy.sv
// Word-by-word copier driving a Wishbone master: one read then one write per word, >= 6 cycles/word.
// Waits on the master's active flag before every new request; abort drains the word in flight.
module wb_block_copy
    import wb_block_copy_pkg::*;
#(
    parameter int dw = 32,
    parameter int aw = 32,
    parameter int LW = 16
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          cfg_start,
    input  logic          cfg_abort,
    input  logic [aw-1:0] cfg_src,
    input  logic [aw-1:0] cfg_dst,
    input  logic [LW-1:0] cfg_len,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] words_done,
    output logic          start,
    output logic [aw-1:0] address,
    output logic [3:0]    selection,
    output logic          write,
    output logic [dw-1:0] data_wr,
    input  logic          active,
    input  logic [dw-1:0] data_rd
);

    state_t        state;
    logic [aw-1:0] src_ptr;
    logic [aw-1:0] dst_ptr;
    logic [LW-1:0] len_left;
    logic          abort_pend;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_done <= '0;
            start      <= 1'b0;
            address    <= '0;
            selection  <= '0;
            write      <= 1'b0;
            data_wr    <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            len_left   <= '0;
            abort_pend <= 1'b0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            if (state != S_IDLE && cfg_abort)
                abort_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        busy <= 1'b1;
                        if (cfg_len != '0) begin
                            src_ptr    <= cfg_src;
                            dst_ptr    <= cfg_dst;
                            len_left   <= cfg_len;
                            words_done <= '0;
                            start      <= 1'b1;
                            write      <= 1'b0;
                            address    <= cfg_src;
                            selection  <= SEL_ALL;
                            state      <= S_RD_REQ;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_RD_REQ: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (!active) begin
                        data_wr   <= data_rd;
                        start     <= 1'b1;
                        write     <= 1'b1;
                        address   <= dst_ptr;
                        selection <= SEL_ALL;
                        state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (!active) begin
                        words_done <= words_done + LW'(1);
                        src_ptr    <= src_ptr + aw'(ADDR_STRIDE);
                        dst_ptr    <= dst_ptr + aw'(ADDR_STRIDE);
                        len_left   <= len_left - LW'(1);
                        // An abort arriving in this very cycle also stops the next read.
                        if (len_left == LW'(1) || abort_pend || cfg_abort) begin
                            state <= S_FINISH;
                        end else begin
                            start     <= 1'b1;
                            write     <= 1'b0;
                            address   <= src_ptr + aw'(ADDR_STRIDE);
                            selection <= SEL_ALL;
                            state     <= S_RD_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_block_copy.sv
// Directed plus randomized bench for wb_block_copy with a latency-programmable slave master model.
module tb_wb_block_copy;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        cfg_start;
    logic        cfg_abort;
    logic [31:0] cfg_src;
    logic [31:0] cfg_dst;
    logic [15:0] cfg_len;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic        active;
    logic [31:0] data_rd;

    wb_block_copy #(.dw(32), .aw(32), .LW(16)) dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_src    (cfg_src),
        .cfg_dst    (cfg_dst),
        .cfg_len    (cfg_len),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .start      (start),
        .address    (address),
        .selection  (selection),
        .write      (write),
        .data_wr    (data_wr),
        .active     (active),
        .data_rd    (data_rd)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 1;
    int cnt = 0;
    int viol = 0;
    int sel_err = 0;
    int done_cnt = 0;
    logic [31:0] salt = 32'h1234_5678;
    logic [31:0] pend_addr = '0;
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    // Slave: active rises the cycle after start, stays high lat cycles; read data valid only on the falling cycle.
    always @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            active  <= 1'b0;
            data_rd <= '0;
            cnt     <= 0;
        end else begin
            if (start) begin
                if (active) viol++;
                if (selection !== 4'hF) sel_err++;
                if (write) begin
                    wr_addr_q.push_back(address);
                    wr_data_q.push_back(data_wr);
                end else begin
                    rd_addr_q.push_back(address);
                    pend_addr <= address;
                end
                active  <= 1'b1;
                cnt     <= lat - 1;
                data_rd <= $urandom;
            end else if (active) begin
                if (cnt == 0) begin
                    active  <= 1'b0;
                    data_rd <= rd_fn(pend_addr);
                end else begin
                    cnt     <= cnt - 1;
                    data_rd <= $urandom;
                end
            end else begin
                data_rd <= $urandom;
            end
        end
    end

    always @(posedge wb_clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        viol     = 0;
        sel_err  = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge wb_clk);
        repeat (3) @(negedge wb_clk);
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input int lt);
        clear_log();
        lat = lt;
        @(negedge wb_clk);
        cfg_src   = s;
        cfg_dst   = d;
        cfg_len   = l;
        cfg_start = 1'b1;
        @(negedge wb_clk);
        cfg_start = 1'b0;
    endtask

    // Reference: word i is read from s+4i and written to d+4i (mod 2^32) with the data the slave returned.
    task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] ea, eb;
        check({tag, ".rd_count"}, rd_addr_q.size(), n);
        check({tag, ".wr_count"}, wr_addr_q.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = s + 32'(4 * i);
            eb = d + 32'(4 * i);
            if (i < rd_addr_q.size()) check({tag, ".rd_addr"}, rd_addr_q[i], ea);
            if (i < wr_addr_q.size()) begin
                check({tag, ".wr_addr"}, wr_addr_q[i], eb);
                check({tag, ".wr_data"}, wr_data_q[i], rd_fn(ea));
            end
        end
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".words_done"}, words_done, n);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".start_while_active"}, viol, 0);
        check({tag, ".selection"}, sel_err, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".start"}, start, 0);
        check({tag, ".write"}, write, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".selection"}, selection, 0);
        check({tag, ".address"}, address, 0);
        check({tag, ".data_wr"}, data_wr, 0);
        check({tag, ".words_done"}, words_done, 0);
    endtask

    initial begin
        logic [31:0] s, d;
        logic [15:0] l;
        int          lt;
        int          seen;

        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_src   = '0;
        cfg_dst   = '0;
        cfg_len   = '0;
        wb_rst_n  = 1'b1;
        #1 wb_rst_n = 1'b0;
        repeat (3) @(negedge wb_clk);
        check_zero_outputs("reset");
        wb_rst_n = 1'b1;
        repeat (2) @(negedge wb_clk);

        // Basic three-word copy, one-cycle slave.
        launch(32'h100, 32'h200, 16'd3, 1);
        wait_done();
        check_copy("basic", 32'h100, 32'h200, 3);

        // Zero length: done two cycles after the request, no transaction.
        clear_log();
        cfg_len   = 16'd0;
        cfg_start = 1'b1;
        @(negedge wb_clk);
        cfg_start = 1'b0;
        check("len0.done_early", done, 0);
        check("len0.busy", busy, 1);
        @(negedge wb_clk);
        check("len0.done", done, 1);
        check("len0.busy_after", busy, 0);
        repeat (3) @(negedge wb_clk);
        check("len0.done_pulses", done_cnt, 1);
        check("len0.transactions", rd_addr_q.size() + wr_addr_q.size(), 0);

        // Source pointer wraps.
        launch(32'hFFFF_FFFC, 32'h0000_0400, 16'd2, 2);
        wait_done();
        check_copy("wrap", 32'hFFFF_FFFC, 32'h0000_0400, 2);

        // Abort during the first read wait.
        launch(32'h1000, 32'h2000, 16'd5, 3);
        seen = 0;
        for (int i = 0; i < 50 && !active; i++) @(negedge wb_clk);
        check("abort.reached_rd_wait", {active, write}, 2'b10);
        cfg_abort = 1'b1;
        @(negedge wb_clk);
        cfg_abort = 1'b0;
        wait_done();
        check_copy("abort", 32'h1000, 32'h2000, 1);

        // Reset mid-write abandons the copy silently.
        launch(32'h3000, 32'h4000, 16'd4, 3);
        for (int i = 0; i < 100 && !(active && write); i++) @(negedge wb_clk);
        check("rst.reached_wr_wait", {active, write, busy}, 3'b111);
        wb_rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        done_cnt = 0;
        repeat (3) @(negedge wb_clk);
        check("rst.no_done", done_cnt, 0);
        wb_rst_n = 1'b1;
        launch(32'h5000, 32'h6000, 16'd2, 2);
        wait_done();
        check_copy("after_rst", 32'h5000, 32'h6000, 2);

        // Slow slave, second start while busy must be ignored.
        launch(32'h7000, 32'h8000, 16'd3, 5);
        repeat (4) @(negedge wb_clk);
        cfg_src   = 32'hDEAD_0000;
        cfg_dst   = 32'hBEEF_0000;
        cfg_len   = 16'd7;
        cfg_start = 1'b1;
        @(negedge wb_clk);
        cfg_start = 1'b0;
        wait_done();
        check_copy("restart_ignored", 32'h7000, 32'h8000, 3);

        // Randomized copies against the reference rule.
        for (int k = 0; k < 5; k++) begin
            salt = $urandom;
            s    = $urandom & 32'hFFFF_FFFC;
            d    = $urandom & 32'hFFFF_FFFC;
            l    = 16'($urandom_range(1, 6));
            lt   = $urandom_range(1, 4);
            launch(s, d, l, lt);
            wait_done();
            check_copy($sformatf("rand%0d", k), s, d, int'(l));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_block_copy.md
WB_BLOCK_COPY -- requirements
Module: wb_block_copy

Interface
REQ-001 Parameter dw, default 32, data width, matches the downstream Wishbone master interface.
REQ-002 Parameter aw, default 32, address width.
REQ-003 Parameter LW, default 16, transfer-length counter width in words.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 wb_clk  input  1  clock; all state changes on the rising edge.
REQ-006 wb_rst_n  input  1  asynchronous active-low reset.
REQ-007 cfg_start  input  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-008 cfg_abort  input  1  stop after the transaction in flight completes.
REQ-009 cfg_src  input  aw  first source word address, byte address, 4-byte aligned.
REQ-010 cfg_dst  input  aw  first destination word address, byte address, 4-byte aligned.
REQ-011 cfg_len  input  LW  number of words to copy.
REQ-012 busy  output  1  high while any state other than IDLE is active.
REQ-013 done  output  1  one-cycle pulse when a copy completes or is aborted.
REQ-014 words_done  output  LW  count of words fully written in the current or last copy.
REQ-015 start  output  1  one-cycle transaction request to the downstream master.
REQ-016 address  output  aw  transaction address to the master.
REQ-017 selection  output  4  byte lanes; SHALL always be 4'hF when start is high.
REQ-018 write  output  1  1 = write, 0 = read.
REQ-019 data_wr  output  dw  write data: the last captured read word.
REQ-020 active  input  1  master busy; goes high the cycle after start and low when the transaction ends.
REQ-021 data_rd  input  dw  master read data; valid in the cycle active is first seen low after a read.

Function
REQ-022 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH. All outputs are registered.
REQ-023 IDLE with cfg_start=1 and cfg_len!=0: latch src, dst and len; clear words_done; go to RD_REQ.
REQ-024 IDLE with cfg_start=1 and cfg_len=0: go directly to FINISH; no start is issued.
REQ-025 RD_REQ:
- start=1, write=0, address=src pointer, for exactly one cycle.
- Next state is RD_WAIT.
REQ-026 RD_WAIT: on the first cycle with active=0, capture data_rd into the data register and go to WR_REQ.
REQ-027 WR_REQ:
- start=1, write=1, address=dst pointer, data_wr=data register, for exactly one cycle.
- Next state is WR_WAIT.
REQ-028 WR_WAIT: on the first cycle with active=0:
- increment words_done.
- add 4 to both pointers.
- go to FINISH if the remaining length reaches 0 or an abort is pending; otherwise go to RD_REQ.
REQ-029 Pointers SHALL increment modulo 2^aw; wrap-around is silent.
REQ-030 cfg_abort seen in any non-IDLE state sets a pending flag:
- The in-flight read and write SHALL both complete.
- No further read SHALL be issued.
REQ-031 FINISH: done=1 for one cycle, clear the abort flag, return to IDLE.
REQ-032 cfg_start seen while not in IDLE SHALL be ignored.
REQ-033 start SHALL never be asserted while active=1.
REQ-034 One word costs at least 6 cycles, plus the master's ack latency on each transaction.

Reset
REQ-035 While wb_rst_n=0, all of the following SHALL be forced immediately, regardless of the clock:
- state = IDLE.
- start, write, busy, done = 0.
- selection, address, data_wr, words_done, internal pointers, length and abort flag = 0.
REQ-036 Reset during a transfer SHALL abandon it and SHALL NOT pulse done.

Structure
REQ-037 A shared package SHALL hold:
- state encodings.
- SEL_ALL = 4'hF.
- ADDR_STRIDE = 4.
REQ-038 The block SHALL be a single module; no sub-module is required.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- src=0x100, dst=0x200, len=3, slave ack after 1 cycle -> reads at 0x100/0x104/0x108, writes at 0x200/0x204/0x208 with matching data; done pulse once; words_done=3.
- len=0 -> done pulses 2 cycles after cfg_start; start stays 0.
- src=0xFFFFFFFC, len=2 -> second read at 0x00000000.
- cfg_abort during the first RD_WAIT of len=5 -> exactly one read and one write; words_done=1; done pulses.
- wb_rst_n low during WR_WAIT -> all outputs 0 at once; no done; a fresh copy afterwards runs correctly.
- Slave ack delayed 5 cycles, cfg_start re-pulsed while busy -> start never high while active=1; second cfg_start ignored.
